// File: rtl/audio_pkg.sv
// audio_pkg
// Shared constants for the block-based audio effects engine: frame geometry,
// sample width, debug bus width and the FSM state encodings.
package audio_pkg;

    localparam int SAMPLE_W         = 16;
    localparam int NUM_WORDS        = 64;
    localparam int SAMPLES_PER_WORD = 32;
    localparam int FRAME_LEN        = 2048;
    localparam int NUM_BINS         = 2048;
    localparam int FFT_BUS_SIZE     = 44;
    localparam int WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;

    // FSM state encodings (kept as plain constants for legacy tools)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/audio_effect_lane.sv
// audio_effect_lane
// Combinational overdrive + tremolo for a single signed sample.
// Ports:
//   s            in   signed sample
//   n            in   sample position in the frame (drives the tremolo triangle)
//   overdrive_en in   overdrive stage enable
//   m            in   overdrive drive amount (clip threshold 32767 >> m, gain 2^m)
//   tremolo_en   in   tremolo stage enable
//   y            out  processed sample
module audio_effect_lane
    import audio_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] s,
    input  logic        [10:0]         n,
    input  logic                       overdrive_en,
    input  logic        [3:0]          m,
    input  logic                       tremolo_en,
    output logic signed [SAMPLE_W-1:0] y
);

    logic signed [SAMPLE_W-1:0] thresh;
    logic signed [SAMPLE_W-1:0] clamped;
    logic signed [SAMPLE_W-1:0] driven;
    logic        [7:0]          g;
    logic signed [24:0]         driven_ext;
    logic signed [24:0]         gain_ext;
    logic signed [24:0]         prod;

    // Overdrive clips to +/-T then scales back up by 2^m, so the shifted
    // result can never leave the 16-bit range. Tremolo multiplies by a gain
    // of (256+g)/512, where g is a triangle that rises over the first half
    // of the frame and falls over the second.
    always_comb begin
        thresh = $signed(16'h7FFF >> m);
        if (s > thresh) begin
            clamped = thresh;
        end else if (s < -thresh) begin
            clamped = -thresh;
        end else begin
            clamped = s;
        end
        driven     = overdrive_en ? (clamped <<< m) : s;
        g          = n[10] ? ~n[9:2] : n[9:2];
        driven_ext = {{9{driven[SAMPLE_W-1]}}, driven};
        gain_ext   = {16'b0, 1'b1, g};
        prod       = driven_ext * gain_ext;
        y          = tremolo_en ? prod[24:9] : driven;
    end

endmodule

// File: rtl/audio_processor.sv
// audio_processor
// Holds one 2048-sample frame (64 x 512-bit words). On start it walks the
// frame one sample per cycle, applying overdrive then tremolo in place, and
// pulses done when the last sample has been written back.
// Ports:
//   clk, rst_n               clock; asynchronous active-high reset (despite the name)
//   start                    begin processing (only honoured in IDLE)
//   data_wr_en/input_index/data_in    host frame word write (IDLE only)
//   pitch_shift_*, freq_coeff_*       spectral controls, stored only
//   tremolo_enable_*, overdrive_*     effect configuration
//   output_index/data_out    combinational frame word read
//   done                     one-cycle completion pulse
module audio_processor
    import audio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 data_wr_en,
    input  logic [5:0]           input_index,
    input  logic [WORD_W-1:0]    data_in,
    input  logic                 pitch_shift_wr_en,
    input  logic [4:0]           pitch_shift_semitones,
    input  logic                 freq_coeff_wr_en,
    input  logic [10:0]          freq_coeff_index,
    input  logic [7:0]           freq_coeff_in,
    input  logic                 tremolo_enable_wr_en,
    input  logic                 tremolo_enable_in,
    input  logic                 overdrive_enable_wr_en,
    input  logic                 overdrive_enable_in,
    input  logic                 overdrive_magnitude_wr_en,
    input  logic [3:0]           overdrive_magnitude,
    input  logic [5:0]           output_index,
    output logic [WORD_W-1:0]    data_out,
    output logic                 done
);

    logic [WORD_W-1:0]          frame_mem [NUM_WORDS];
    logic [1:0]                 state;
    logic [10:0]                n;

    logic                       tremolo_en;
    logic                       overdrive_en;
    logic [3:0]                 drive_m;
    logic signed [4:0]          pitch;
    logic [7:0]                 eq_coeff [NUM_BINS];

    logic                       snap_tremolo;
    logic                       snap_overdrive;
    logic [3:0]                 snap_m;

    logic [FFT_BUS_SIZE-1:0]    fft_output_full;

    logic signed [SAMPLE_W-1:0] cur_sample;
    logic signed [SAMPLE_W-1:0] proc_sample;
    logic [8:0]                 lane_bit;

    // Sample n lives in word n[10:5], lane n[4:0]; the spectral stage is
    // identity in this revision so the raw sample feeds the effect lane.
    assign lane_bit   = {n[4:0], 4'b0};
    assign cur_sample = frame_mem[n[10:5]][lane_bit +: SAMPLE_W];
    assign data_out   = frame_mem[output_index];

    audio_effect_lane u_lane (
        .s            (cur_sample),
        .n            (n),
        .overdrive_en (snap_overdrive),
        .m            (snap_m),
        .tremolo_en   (snap_tremolo),
        .y            (proc_sample)
    );

    // Configuration registers accept writes in any state; the effect
    // settings are snapshotted separately at start so mid-frame writes do
    // not disturb the frame being processed.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tremolo_en   <= 1'b0;
            overdrive_en <= 1'b0;
            drive_m      <= 4'd0;
            pitch        <= 5'sd0;
            for (int i = 0; i < NUM_BINS; i++) begin
                eq_coeff[i] <= 8'h01;
            end
        end else begin
            if (tremolo_enable_wr_en)      tremolo_en <= tremolo_enable_in;
            if (overdrive_enable_wr_en)    overdrive_en <= overdrive_enable_in;
            if (overdrive_magnitude_wr_en) drive_m <= overdrive_magnitude;
            if (pitch_shift_wr_en)         pitch <= pitch_shift_semitones;
            if (freq_coeff_wr_en)          eq_coeff[freq_coeff_index] <= freq_coeff_in;
        end
    end

    // Control FSM: IDLE waits for start, BUSY steps n through the frame,
    // DONE raises done for a single cycle before returning to IDLE.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state           <= IDLE;
            n               <= 11'd0;
            done            <= 1'b0;
            snap_tremolo    <= 1'b0;
            snap_overdrive  <= 1'b0;
            snap_m          <= 4'd0;
            fft_output_full <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= BUSY;
                        n              <= 11'd0;
                        snap_tremolo   <= tremolo_en;
                        snap_overdrive <= overdrive_en;
                        snap_m         <= drive_m;
                    end
                end
                BUSY: begin
                    fft_output_full <= {{6{proc_sample[SAMPLE_W-1]}}, proc_sample, 22'b0};
                    n               <= n + 11'd1;
                    if (n == 11'(FRAME_LEN - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame buffer is deliberately never cleared by reset. The host owns it
    // in IDLE; during BUSY the processed sample is written back in place.
    always_ff @(posedge clk) begin
        if (state == IDLE && data_wr_en) begin
            frame_mem[input_index] <= data_in;
        end else if (state == BUSY) begin
            frame_mem[n[10:5]][lane_bit +: SAMPLE_W] <= proc_sample;
        end
    end

endmodule

// File: tb/tb_audio_processor.sv
// tb_audio_processor
// Directed self-checking bench for audio_processor: latency, identity path,
// overdrive and tremolo values, ignored mid-frame start/writes, and reset
// during processing.
module tb_audio_processor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         data_wr_en;
    logic [5:0]   input_index;
    logic [511:0] data_in;
    logic         pitch_shift_wr_en;
    logic [4:0]   pitch_shift_semitones;
    logic         freq_coeff_wr_en;
    logic [10:0]  freq_coeff_index;
    logic [7:0]   freq_coeff_in;
    logic         tremolo_enable_wr_en;
    logic         tremolo_enable_in;
    logic         overdrive_enable_wr_en;
    logic         overdrive_enable_in;
    logic         overdrive_magnitude_wr_en;
    logic [3:0]   overdrive_magnitude;
    logic [5:0]   output_index;
    logic [511:0] data_out;
    logic         done;

    int checkCount = 0;
    int failCount  = 0;
    logic signed [15:0] model [2048];

    always #5 clk = ~clk;

    audio_processor dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .start                     (start),
        .data_wr_en                (data_wr_en),
        .input_index               (input_index),
        .data_in                   (data_in),
        .pitch_shift_wr_en         (pitch_shift_wr_en),
        .pitch_shift_semitones     (pitch_shift_semitones),
        .freq_coeff_wr_en          (freq_coeff_wr_en),
        .freq_coeff_index          (freq_coeff_index),
        .freq_coeff_in             (freq_coeff_in),
        .tremolo_enable_wr_en      (tremolo_enable_wr_en),
        .tremolo_enable_in         (tremolo_enable_in),
        .overdrive_enable_wr_en    (overdrive_enable_wr_en),
        .overdrive_enable_in       (overdrive_enable_in),
        .overdrive_magnitude_wr_en (overdrive_magnitude_wr_en),
        .overdrive_magnitude       (overdrive_magnitude),
        .output_index              (output_index),
        .data_out                  (data_out),
        .done                      (done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [511:0] actual,
                               input logic [511:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] packWord(input int w);
        logic [511:0] r;
        for (int l = 0; l < 32; l++) begin
            r[l*16 +: 16] = model[w*32 + l];
        end
        return r;
    endfunction

    task automatic loadFrame();
        for (int w = 0; w < 64; w++) begin
            data_wr_en  = 1'b1;
            input_index = 6'(w);
            data_in     = packWord(w);
            tick();
        end
        data_wr_en = 1'b0;
    endtask

    task automatic readSample(input int idx, output logic [15:0] v);
        output_index = 6'(idx / 32);
        #1;
        v = data_out[(idx % 32)*16 +: 16];
    endtask

    task automatic setEffects(input logic trem, input logic od, input logic [3:0] mag);
        tremolo_enable_wr_en      = 1'b1;
        tremolo_enable_in         = trem;
        overdrive_enable_wr_en    = 1'b1;
        overdrive_enable_in       = od;
        overdrive_magnitude_wr_en = 1'b1;
        overdrive_magnitude       = mag;
        tick();
        tremolo_enable_wr_en      = 1'b0;
        overdrive_enable_wr_en    = 1'b0;
        overdrive_magnitude_wr_en = 1'b0;
    endtask

    // Pulses start and waits (bounded) for done; optionally asserts start and
    // a garbage buffer write for three cycles from cycle injectAt onward.
    task automatic applyStimulus(input int injectAt, output int elapsed);
        start = 1'b1;
        tick();
        start   = 1'b0;
        elapsed = 0;
        while (!done && elapsed < 3000) begin
            if (injectAt >= 0 && elapsed >= injectAt && elapsed < injectAt + 3) begin
                start       = 1'b1;
                data_wr_en  = 1'b1;
                input_index = 6'd0;
                data_in     = '1;
            end else begin
                start      = 1'b0;
                data_wr_en = 1'b0;
            end
            tick();
            elapsed++;
        end
        start      = 1'b0;
        data_wr_en = 1'b0;
    endtask

    task automatic checkSample(input string tag, input int idx, input logic [15:0] exp);
        logic [15:0] v;
        readSample(idx, v);
        checkOutput(tag, 512'(v), 512'(exp));
    endtask

    initial begin
        int lat;
        int extraDone;
        rst_n = 1'b1;
        start = 1'b0;
        data_wr_en = 1'b0;
        input_index = '0;
        data_in = '0;
        pitch_shift_wr_en = 1'b0;
        pitch_shift_semitones = '0;
        freq_coeff_wr_en = 1'b0;
        freq_coeff_index = '0;
        freq_coeff_in = '0;
        tremolo_enable_wr_en = 1'b0;
        tremolo_enable_in = 1'b0;
        overdrive_enable_wr_en = 1'b0;
        overdrive_enable_in = 1'b0;
        overdrive_magnitude_wr_en = 1'b0;
        overdrive_magnitude = '0;
        output_index = '0;

        repeat (3) tick();
        checkOutput("reset_done", 512'(done), 512'(0));
        rst_n = 1'b0;
        tick();

        // Default config: ramp passes through unchanged
        for (int i = 0; i < 2048; i++) model[i] = 16'(i - 1024);
        loadFrame();
        applyStimulus(-1, lat);
        checkOutput("latency_default", 512'(lat), 512'(2049));
        tick();
        checkOutput("done_one_cycle", 512'(done), 512'(0));
        for (int w = 0; w < 64; w++) begin
            output_index = 6'(w);
            #1;
            checkOutput($sformatf("ramp_word%0d", w), data_out, packWord(w));
        end

        // Overdrive m=4
        for (int i = 0; i < 2048; i++) model[i] = 16'sd0;
        model[0] = 16'sd5000;
        model[1] = 16'sd1000;
        model[2] = -16'sd100;
        model[3] = -16'sd9000;
        setEffects(1'b0, 1'b1, 4'd4);
        loadFrame();
        applyStimulus(-1, lat);
        checkOutput("latency_od", 512'(lat), 512'(2049));
        checkSample("od_5000", 0, 16'sd32752);
        checkSample("od_1000", 1, 16'sd16000);
        checkSample("od_m100", 2, -16'sd1600);
        checkSample("od_m9000", 3, -16'sd32752);

        // Overdrive m=0 clamps only the most negative value
        model[0] = -16'sd32768;
        model[1] = 16'sd32767;
        model[2] = 16'sd0;
        model[3] = 16'sd0;
        setEffects(1'b0, 1'b1, 4'd0);
        loadFrame();
        applyStimulus(-1, lat);
        checkSample("od0_min", 0, -16'sd32767);
        checkSample("od0_max", 1, 16'sd32767);

        // Tremolo on constant 1000
        for (int i = 0; i < 2048; i++) model[i] = 16'sd1000;
        setEffects(1'b1, 1'b0, 4'd0);
        loadFrame();
        applyStimulus(-1, lat);
        checkSample("trem_n0", 0, 16'sd500);
        checkSample("trem_n1020", 1020, 16'sd998);
        checkSample("trem_n1024", 1024, 16'sd998);
        checkSample("trem_n2047", 2047, 16'sd500);

        // Spectral controls stored only; mid-frame start and writes ignored
        setEffects(1'b0, 1'b0, 4'd0);
        pitch_shift_wr_en = 1'b1;
        pitch_shift_semitones = 5'b11110;
        tick();
        pitch_shift_wr_en = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            freq_coeff_wr_en = 1'b1;
            freq_coeff_index = 11'(i);
            freq_coeff_in    = 8'd3;
            tick();
        end
        freq_coeff_wr_en = 1'b0;
        for (int i = 0; i < 2048; i++) model[i] = 16'(i - 1024);
        loadFrame();
        applyStimulus(500, lat);
        checkOutput("latency_inject", 512'(lat), 512'(2049));
        extraDone = 0;
        for (int c = 0; c < 2100; c++) begin
            tick();
            if (done) extraDone++;
        end
        checkOutput("inject_extra_done", 512'(extraDone), 512'(0));
        for (int w = 0; w < 64; w += 9) begin
            output_index = 6'(w);
            #1;
            checkOutput($sformatf("inject_word%0d", w), data_out, packWord(w));
        end

        // Reset after 1000 BUSY cycles with tremolo on
        for (int i = 0; i < 2048; i++) model[i] = 16'sd1000;
        setEffects(1'b1, 1'b0, 4'd0);
        loadFrame();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (1000) tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        extraDone = 0;
        for (int c = 0; c < 2100; c++) begin
            tick();
            if (done) extraDone++;
        end
        checkOutput("rst_no_done", 512'(extraDone), 512'(0));
        checkSample("rst_s0", 0, 16'sd500);
        checkSample("rst_s500", 500, 16'sd744);
        checkSample("rst_s1500", 1500, 16'sd1000);
        checkSample("rst_s2047", 2047, 16'sd1000);
        applyStimulus(-1, lat);
        checkOutput("latency_after_rst", 512'(lat), 512'(2049));
        checkSample("after_rst_s0", 0, 16'sd500);
        checkSample("after_rst_s2047", 2047, 16'sd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/audio_processor.md
Name: audio_processor

Overview:
- Block-based audio effects engine. Holds one frame of 2048 signed 16-bit samples, loaded as 64 × 512-bit words.
- On start, processes the frame in place one sample per cycle, then pulses done; the host reads back 64 words.
- Sits between the host frame loader (audio storage) and the frame writer (audio reader).
- Spectral controls (pitch shift, EQ coefficients) are latched here for the spectral core; in this revision the spectral path is identity.

Parameters:
- SAMPLE_W, 16: sample width, signed two's complement.
- NUM_WORDS, 64: bus words per frame.
- FFT_BUS_SIZE, 44: width of internal debug register fft_output_full ({real, imag}, 22 bits each).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted when 1 despite the name).
- start  in  1  begin processing the frame (sampled only in IDLE).
- data_wr_en  in  1  write data_in into frame word input_index.
- input_index  in  6  frame word write address.
- data_in  in  512  32 samples; sample k at bits [16k+15:16k].
- pitch_shift_wr_en  in  1  latch pitch_shift_semitones.
- pitch_shift_semitones  in  5  signed semitone shift, -16..15.
- freq_coeff_wr_en  in  1  write an EQ coefficient.
- freq_coeff_index  in  11  EQ bin, 0..2047.
- freq_coeff_in  in  8  EQ coefficient value.
- tremolo_enable_wr_en / tremolo_enable_in  in  1/1  tremolo on/off.
- overdrive_enable_wr_en / overdrive_enable_in  in  1/1  overdrive on/off.
- overdrive_magnitude_wr_en / overdrive_magnitude  in  1/4  overdrive drive amount m.
- output_index  in  6  frame word read address.
- data_out  out  512  frame word output_index, combinational read.
- done  out  1  one-cycle pulse at end of processing.

Behaviour:
- Reset values:
  - FSM=IDLE, done=0, sample counter n=0.
  - tremolo_en=0, overdrive_en=0, m=0, pitch=0.
  - All 2048 EQ coefficients = 8'h01 (unity); fft_output_full=0.
  - Frame buffer is not cleared.
- Frame mapping: sample n lives in word n[10:5], lane n[4:0]. Buffer writes happen on clk when data_wr_en=1 in IDLE; data_wr_en is ignored in BUSY.
- Config registers: written on the cycle their wr_en is high, in any state. Effect settings are snapshotted at start and used for the whole frame.
- FSM:
  - IDLE → BUSY on start=1. n=0 on entry.
  - BUSY: every cycle read sample n, compute y, write y back to sample n, n++.
  - After n=2047 is written → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE.
  - start in BUSY or DONE is ignored.
  - Latency: start sampled at edge 0; done is high after edge 2049.
- Per-sample datapath, s signed 16-bit:
  - Spectral stage: identity in this revision (pitch and coefficients stored only).
  - Overdrive, when enabled: T = 32767 >> m; c = clamp(s, -T, +T); s' = c << m (fits 16 bits by construction).
  - Tremolo, when enabled: g = n[10] ? ~n[9:2] : n[9:2] (8-bit triangle, period 2048 samples); y = (s' × (256+g)) >>> 9 (arithmetic shift, 25-bit product).
  - Order is overdrive then tremolo; a disabled stage passes its input unchanged.
- fft_output_full = {sign-extend(y) to 22 bits, 22'b0}, updated each BUSY cycle.
- data_out during BUSY shows the partially processed buffer; the host reads only after done.
- Reset mid-BUSY: immediately IDLE with done=0. Samples already written stay processed.

Decomposition:
- Package audio_pkg: SAMPLE_W, NUM_WORDS, SAMPLES_PER_WORD=32, FRAME_LEN=2048, NUM_BINS=2048, FSM state enum {IDLE, BUSY, DONE}.
- Sub-module audio_effect_lane: combinational overdrive + tremolo for one sample. Inputs s, n, snapshot config; output y.

Test Plan:
- Default config: load ramp (sample n = n−1024), start → done pulse exactly 2049 cycles after start; all 64 words read back equal the input.
- Overdrive en, m=4 (T=2047): inputs 5000, 1000, −100, −9000 → 32752, 16000, −1600, −32752.
- Tremolo en, all samples 1000: n=0 → 500; n=1020 (g=255) → 998; n=1024 (g=255) → 998; n=2047 (g=0) → 500.
- Overdrive m=0 with tremolo off: −32768 → −32767; +32767 → +32767.
- start and data_wr_en asserted mid-BUSY → ignored: one done pulse only, buffer holds processed original frame. Pitch=−2 and all coeffs=3 → output still equals input.
- rst_n=1 at cycle 1000 of BUSY → done never pulses; samples 0..~998 processed, rest raw; next start completes normally with default config.
